// File: rtl/gameover_screen_ctrl.sv
// Game-over sequencer: freezes play, blinks then holds the banner until restart,
// and produces the banner rectangle qualifier and pixel offsets for the drawer.
module gameover_screen_ctrl #(
  parameter int unsigned TOP_LEFT_X    = 170,
  parameter int unsigned TOP_LEFT_Y    = 190,
  parameter int unsigned BANNER_W      = 300,
  parameter int unsigned BANNER_H      = 100,
  parameter int unsigned FREEZE_FRAMES = 30,
  parameter int unsigned BLINK_PERIOD  = 15,
  parameter int unsigned BLINK_TOGGLES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        playerDead,
  input  logic        timeUp,
  input  logic        restartKey,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        freezeGame,
  output logic        bannerVisible,
  output logic        restartReq,
  output logic [2:0]  gameOverState
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CRD_W = 12;

  localparam logic [CRD_W-1:0] X_LO = CRD_W'(TOP_LEFT_X);
  localparam logic [CRD_W-1:0] X_HI = CRD_W'(TOP_LEFT_X + BANNER_W);
  localparam logic [CRD_W-1:0] Y_LO = CRD_W'(TOP_LEFT_Y);
  localparam logic [CRD_W-1:0] Y_HI = CRD_W'(TOP_LEFT_Y + BANNER_H);

  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(BLINK_TOGGLES - 1);

  typedef enum logic [2:0] {
    ST_PLAY    = 3'd0,
    ST_FREEZE  = 3'd1,
    ST_BLINK   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RESTART = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   toggle_cnt_q;
  logic               key_prev_q;
  logic               visible_q;
  logic               restart_req_q;
  logic               inside_q;
  logic [10:0]        off_x_q;
  logic [10:0]        off_y_q;
  logic               key_edge_c;
  logic               in_region_c;

  assign key_edge_c = restartKey & ~key_prev_q;

  // Sequencer: visibility only changes on frame boundaries or state entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_PLAY;
      frame_cnt_q   <= '0;
      toggle_cnt_q  <= '0;
      key_prev_q    <= 1'b0;
      visible_q     <= 1'b0;
      restart_req_q <= 1'b0;
    end else begin
      key_prev_q    <= restartKey;
      restart_req_q <= 1'b0;
      case (state_q)
        ST_PLAY: begin
          frame_cnt_q <= '0;
          if (playerDead || timeUp) state_q <= ST_FREEZE;
        end
        ST_FREEZE: begin
          if (startOfFrame) begin
            if (frame_cnt_q == FREEZE_LAST) begin
              state_q      <= ST_BLINK;
              visible_q    <= 1'b1;
              frame_cnt_q  <= '0;
              toggle_cnt_q <= '0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        ST_BLINK: begin
          if (startOfFrame) begin
            if (frame_cnt_q == PERIOD_LAST) begin
              frame_cnt_q  <= '0;
              toggle_cnt_q <= toggle_cnt_q + 1'b1;
              visible_q    <= ~visible_q;
              // Last toggle lands in HOLD visible regardless of parity.
              if (toggle_cnt_q == TOGGLE_LAST) begin
                state_q   <= ST_HOLD;
                visible_q <= 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          visible_q <= 1'b1;
          if (key_edge_c) begin
            state_q       <= ST_RESTART;
            restart_req_q <= 1'b1;
          end
        end
        ST_RESTART: begin
          visible_q <= 1'b0;
          state_q   <= ST_PLAY;
        end
        default: state_q <= ST_PLAY;
      endcase
    end
  end

  assign in_region_c = visible_q &&
                       ({1'b0, pixelX} >= X_LO) && ({1'b0, pixelX} < X_HI) &&
                       ({1'b0, pixelY} >= Y_LO) && ({1'b0, pixelY} < Y_HI);

  // Region qualifier and offsets, one cycle behind the pixel coordinates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q <= 1'b0;
      off_x_q  <= '0;
      off_y_q  <= '0;
    end else begin
      inside_q <= in_region_c;
      off_x_q  <= in_region_c ? (pixelX - 11'(TOP_LEFT_X)) : '0;
      off_y_q  <= in_region_c ? (pixelY - 11'(TOP_LEFT_Y)) : '0;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign bannerVisible   = visible_q;
  assign restartReq      = restart_req_q;
  assign gameOverState   = state_q;
  assign freezeGame      = (state_q != ST_PLAY);

endmodule

// File: tb/tb_gameover_screen_ctrl.sv
// Directed plus randomized bench for gameover_screen_ctrl against a
// frame-count based reference model.
module tb_gameover_screen_ctrl;

  localparam int F         = 3;
  localparam int P         = 2;
  localparam int T         = 4;
  localparam int FRAME_LEN = 16;
  localparam int X0 = 170, Y0 = 190, W = 300, H = 100;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        playerDead = 1'b0;
  logic        timeUp = 1'b0;
  logic        restartKey = 1'b0;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        freezeGame;
  logic        bannerVisible;
  logic        restartReq;
  logic [2:0]  gameOverState;

  gameover_screen_ctrl #(
    .TOP_LEFT_X(170), .TOP_LEFT_Y(190), .BANNER_W(300), .BANNER_H(100),
    .FREEZE_FRAMES(F), .BLINK_PERIOD(P), .BLINK_TOGGLES(T)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .playerDead(playerDead), .timeUp(timeUp),
    .restartKey(restartKey), .InsideRectangle(InsideRectangle),
    .offsetX(offsetX), .offsetY(offsetY), .freezeGame(freezeGame),
    .bannerVisible(bannerVisible), .restartReq(restartReq),
    .gameOverState(gameOverState)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit rand_pix = 1'b1;

  // Model: phase 0 = playing, 1 = game over (sub-state derived from frames seen), 4 = restarting
  int m_phase, m_n, m_ox, m_oy;
  bit m_key_prev, m_vis, m_req, m_inside;

  function automatic int m_state();
    if (m_phase == 0) return 0;
    if (m_phase == 4) return 4;
    if (m_n < F) return 1;
    if (m_n < F + P * T) return 2;
    return 3;
  endfunction

  function automatic bit vis_of(int n);
    int k;
    if (n < F) return 1'b0;
    k = (n - F) / P;
    if (k >= T) return 1'b1;
    return (k % 2) == 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_ox = 0; m_oy = 0;
    m_key_prev = 0; m_vis = 0; m_req = 0; m_inside = 0;
  endtask

  task automatic model_edge();
    int px, py, st;
    bit key_edge;
    px = int'(pixelX);
    py = int'(pixelY);
    m_inside = m_vis && px >= X0 && px < X0 + W && py >= Y0 && py < Y0 + H;
    m_ox = m_inside ? px - X0 : 0;
    m_oy = m_inside ? py - Y0 : 0;
    key_edge = restartKey && !m_key_prev;
    m_key_prev = restartKey;
    st = m_state();
    m_req = 0;
    case (st)
      0: if (playerDead || timeUp) begin m_phase = 1; m_n = 0; end
      1, 2: if (startOfFrame) m_n++;
      3: if (key_edge) begin m_phase = 4; m_req = 1; end
      default: m_phase = 0;
    endcase
    if (m_phase == 0) m_vis = 0;
    else if (m_phase == 4) m_vis = 1;
    else m_vis = vis_of(m_n);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  task automatic check_all();
    chk("state", 32'(gameOverState), 32'(m_state()));
    chk("freezeGame", 32'(freezeGame), 32'(m_state() != 0));
    chk("bannerVisible", 32'(bannerVisible), 32'(m_vis));
    chk("restartReq", 32'(restartReq), 32'(m_req));
    chk("InsideRectangle", 32'(InsideRectangle), 32'(m_inside));
    chk("offsetX", 32'(offsetX), 32'(m_ox));
    chk("offsetY", 32'(offsetY), 32'(m_oy));
  endtask

  task automatic step();
    startOfFrame = (cyc % FRAME_LEN == 0);
    if (rand_pix) begin
      pixelX = 11'($urandom_range(140, 500));
      pixelY = 11'($urandom_range(170, 310));
    end
    @(posedge clk);
    cyc++;
    if (resetN) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int st, input int max_steps, input string tag);
    int i;
    i = 0;
    while (m_state() != st && i < max_steps) begin
      step();
      i++;
    end
    chk(tag, 32'(gameOverState), 32'(st));
  endtask

  task automatic pix_step(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    step();
  endtask

  task automatic async_reset_check();
    resetN = 1'b0;
    #1;
    model_reset();
    check_all();
    run(3);
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    async_reset_check();

    // Idle frames: nothing must happen
    run(5 * FRAME_LEN);

    // Single-cycle game-over pulse, freeze, blink; key held into HOLD
    playerDead = 1'b1;
    step();
    playerDead = 1'b0;
    run_until(2, (F + 1) * FRAME_LEN, "reach_blink");
    restartKey = 1'b1;
    run_until(3, (P * T + 1) * FRAME_LEN, "reach_hold");
    run(10 * FRAME_LEN);

    // Region mapping while banner is steady
    rand_pix = 1'b0;
    pix_step(170, 190);
    pix_step(469, 289);
    pix_step(470, 190);
    pix_step(169, 250);
    pix_step(300, 290);
    pix_step(300, 189);
    rand_pix = 1'b1;

    // Fresh key edge restarts
    restartKey = 1'b0;
    run(3);
    restartKey = 1'b1;
    step();
    chk("restart_pulse", 32'(restartReq), 32'(1));
    step();
    chk("back_to_play", 32'(gameOverState), 32'(0));
    run(3);
    restartKey = 1'b0;

    // Both events together; key presses during FREEZE are ignored
    playerDead = 1'b1;
    timeUp = 1'b1;
    step();
    step();
    playerDead = 1'b0;
    timeUp = 1'b0;
    restartKey = 1'b1;
    run(3);
    restartKey = 1'b0;
    run_until(2, (F + 1) * FRAME_LEN, "reach_blink2");
    run(3 * FRAME_LEN);

    // Reset in the middle of blinking
    async_reset_check();
    run(2 * FRAME_LEN);

    // Random traffic
    repeat (3000) begin
      playerDead = ($urandom_range(0, 199) == 0);
      timeUp = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) restartKey = ~restartKey;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
